// File: rtl/counter_seq_pkg.sv
// Shared types and constants for the counter sequencing controller.
// Used by counter_seq_ctrl and ctr_core.
package counter_seq_pkg;

  // Default datapath widths
  localparam int DEF_WIDTH  = 4;
  localparam int DEF_RUNS_W = 8;

  // Controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // All-ones value for a counter of width w (saturation limit)
  function automatic logic [31:0] sat_limit(input int w);
    logic [31:0] v;
    if (w >= 32) begin
      v = '1;
    end else begin
      v = (32'd1 << w) - 32'd1;
    end
    return v;
  endfunction

endpackage

// File: rtl/ctr_core.sv
// Counter datapath: clear, load, and up/down count enable.
// Priority is rst > clr > ld > en; dir=0 counts up, dir=1 counts down.
module ctr_core
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             dir,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_reg;

  // Counter register with clear/load/step priority
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (ld) begin
      count_reg <= ld_val;
    end else if (en) begin
      if (dir) begin
        count_reg <= count_reg - ONE;
      end else begin
        count_reg <= count_reg + ONE;
      end
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/counter_seq_ctrl.sv
// Configures and sequences a ctr_core count run: valid/ready terminal-count
// configuration, start/pause/abort control, one-cycle done pulse and a
// saturating completed-run counter.
// Optional feature: define CTRL_DOWN_EN to add the cfg_down port and
// down-counting runs (term down to 0).
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int RUNS_W = DEF_RUNS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [WIDTH-1:0]  cfg_term,
  input  logic              cfg_reload,
`ifdef CTRL_DOWN_EN
  input  logic              cfg_down,
`endif
  input  logic              start,
  input  logic              pause,
  input  logic              abort,
  output logic [WIDTH-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic [RUNS_W-1:0] run_cnt
);

  localparam logic [RUNS_W-1:0] RUNS_MAX = RUNS_W'(sat_limit(RUNS_W));
  localparam logic [RUNS_W-1:0] RUNS_ONE = RUNS_W'(1);

  state_t              state_reg;
  logic [WIDTH-1:0]    term_reg;
  logic                reload_reg;
  logic                down_reg;
  logic                start_pend_reg;
  logic                busy_reg;
  logic                done_reg;
  logic [RUNS_W-1:0]   run_cnt_reg;

  logic                cfg_fire;
  logic                cfg_down_in;
  logic                active;
  logic                step;
  logic                at_term;
  logic                term_hit;
  logic                launch;
  logic                down_eff;

  logic                core_clr;
  logic                core_en;
  logic                core_ld;
  logic [WIDTH-1:0]    core_ld_val;
  logic [WIDTH-1:0]    core_count;

`ifdef CTRL_DOWN_EN
  assign cfg_down_in = cfg_down;
`else
  assign cfg_down_in = 1'b0;
`endif

  // Configuration is accepted only while no run is in progress
  assign cfg_ready = (state_reg == IDLE) || (state_reg == ARMED);
  assign cfg_fire  = cfg_valid & cfg_ready;

  // A run is launched one edge after start is seen in ARMED, so count=0
  // appears exactly one cycle after the start sample.
  assign launch = start_pend_reg && (state_reg == ARMED);

  // A config arriving on the launch edge is the one the run must use
  assign down_eff = cfg_fire ? cfg_down_in : down_reg;

  // RUN, or HOLD being released, both behave as a counting edge
  assign active   = (state_reg == RUN) || (state_reg == HOLD);
  assign step     = active && !abort && !pause;
  assign at_term  = down_reg ? (core_count == '0) : (core_count == term_reg);
  assign term_hit = step && at_term;

  // Decode counter-core strobes from state and control inputs
  always_comb begin
    core_clr    = 1'b0;
    core_en     = 1'b0;
    core_ld     = 1'b0;
    core_ld_val = cfg_fire ? cfg_term : term_reg;
    if (active && abort) begin
      core_clr = 1'b1;
    end else if (launch) begin
      if (down_eff) begin
        core_ld = 1'b1;
      end else begin
        core_clr = 1'b1;
      end
    end else if (term_hit) begin
      // One-shot holds the terminal value; reload restarts the run
      if (reload_reg) begin
        if (down_reg) begin
          core_ld = 1'b1;
        end else begin
          core_clr = 1'b1;
        end
      end
    end else if (step) begin
      core_en = 1'b1;
    end
  end

  // Sequencing FSM with registered busy/done/run_cnt and latched config
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      term_reg       <= '0;
      reload_reg     <= 1'b0;
      down_reg       <= 1'b0;
      start_pend_reg <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      run_cnt_reg    <= '0;
    end else begin
      done_reg       <= 1'b0;
      start_pend_reg <= start && (state_reg == ARMED);

      if (cfg_fire) begin
        term_reg   <= cfg_term;
        reload_reg <= cfg_reload;
        down_reg   <= cfg_down_in;
      end

      case (state_reg)
        IDLE: begin
          busy_reg <= 1'b0;
          if (cfg_fire) begin
            state_reg <= ARMED;
          end
        end

        ARMED: begin
          if (launch) begin
            state_reg <= RUN;
            busy_reg  <= 1'b1;
          end
        end

        RUN, HOLD: begin
          if (abort) begin
            state_reg <= ARMED;
            busy_reg  <= 1'b0;
          end else if (pause) begin
            state_reg <= HOLD;
            busy_reg  <= 1'b1;
          end else if (at_term) begin
            done_reg <= 1'b1;
            if (run_cnt_reg != RUNS_MAX) begin
              run_cnt_reg <= run_cnt_reg + RUNS_ONE;
            end
            if (reload_reg) begin
              state_reg <= RUN;
              busy_reg  <= 1'b1;
            end else begin
              state_reg <= ARMED;
              busy_reg  <= 1'b0;
            end
          end else begin
            state_reg <= RUN;
            busy_reg  <= 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  ctr_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .clr    (core_clr),
    .en     (core_en),
    .ld     (core_ld),
    .ld_val (core_ld_val),
    .dir    (down_reg),
    .count  (core_count)
  );

  assign count   = core_count;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign run_cnt = run_cnt_reg;

endmodule
